mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IF) and load/store unit (LS) of cpu_top.
//  Fixed priority to LS with a starvation guard for IF; tracks in-flight reads and routes each read-data beat back to its issuer.
//  Sits between cpu_top fetch/LSU stages and the memory macro that replaces the separate imem/dmem arrays.
// PARAMETERS
//  ADDR_W     32  address width, byte address
//  DATA_W     32  data width; byte enables are DATA_W/8 bits
//  MEM_LAT    1   memory read latency in cycles, legal 1..4
//  STARVE_MAX 4   consecutive IF denials (IF requesting, LS granted) before IF is forced to win
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  if_req     in   1         IF read request; addr held stable until if_gnt
//  if_addr    in   ADDR_W    IF address
//  if_gnt     out  1         IF request accepted this cycle
//  if_rvalid  out  1         IF read data valid
//  if_rdata   out  DATA_W    IF read data
//  ls_req     in   1         LS request; all LS inputs held stable until ls_gnt
//  ls_we      in   1         1 = store, 0 = load
//  ls_be      in   DATA_W/8  store byte enables (don't-care for loads)
//  ls_addr    in   ADDR_W    LS address
//  ls_wdata   in   DATA_W    store data
//  ls_gnt     out  1         LS request accepted this cycle
//  ls_rvalid  out  1         LS load data valid
//  ls_rdata   out  DATA_W    LS load data
//  mem_req    out  1         memory access this cycle (memory never stalls)
//  mem_we     out  1         memory write enable
//  mem_be     out  DATA_W/8  memory byte enables (all ones for reads)
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after a read mem_req
// BEHAVIOUR
//  - Grant is combinational from req + starve count: gnt and mem_* in the same cycle as req; at most one gnt per cycle.
//  - Arbitration: LS only -> LS. IF only -> IF. Both -> LS, unless starve_cnt == STARVE_MAX, then IF.
//  - starve_cnt (reg): +1 when if_req && ls_gnt; cleared on if_gnt or when !if_req; saturates at STARVE_MAX.
//  - No request -> mem_req=0, mem_we=0, mem_be=0, mem_addr/mem_wdata=0.
//  - IF access: mem_we=0, mem_be=all ones. LS access: ls_we/ls_be/ls_addr/ls_wdata passed through; LS load forces be=all ones.
//  - Response pipe: MEM_LAT-deep shift register of {vld, owner, is_read}, loaded every cycle with the current grant (vld=0 if none).
//  - Tail slot vld && is_read: owner IF -> if_rvalid=1, if_rdata=mem_rdata; owner LS -> ls_rvalid=1, ls_rdata=mem_rdata.
//  - Non-owner rdata = 0. Stores produce no rvalid. Back-to-back issue every cycle; responses return in issue order.
//  - Read/write ordering is the memory's job: a store granted in cycle N is visible to a read granted in N+1.
//  - Reset: starve_cnt=0, all pipe slots vld=0, so *_rvalid=0 and *_rdata=0 the cycle after rst rises.
//    Gnt and mem_req are forced to 0 while rst=1, regardless of req.
//  - Reset mid-operation: in-flight reads are discarded and never signalled. Requesters re-issue after reset.
//  - Dropping req before gnt is illegal; assertion flags it in simulation.
// STRUCTURE
//  - Package mem_arb_pkg: typedef enum logic {OWN_IF, OWN_LS} owner_e; typedef struct packed {vld, owner_e owner, is_read} resp_slot_t.
//  - Sub-module mem_resp_pipe: parameterised MEM_LAT-stage shift register of resp_slot_t with sync reset.
//  - Top-level: arbitration logic, starve counter, mem_* mux and response demux.
// TESTING
//  1. MEM_LAT=1, if_req=1 for 4 cycles at addr 0,4,8,C, memory preloaded word i=i+1
//     -> if_gnt 4 cycles; if_rvalid in cycles 1..4 with data 1,2,3,4; ls_* idle.
//  2. if_req and ls_req (load 0x100 = 0xDEAD_BEEF) in the same cycle
//     -> ls_gnt=1, if_gnt=0; ls_rvalid next cycle with 0xDEAD_BEEF; if_gnt the cycle after.
//  3. STARVE_MAX=4, ls_req and if_req held high 6 cycles -> ls_gnt cycles 0-3, if_gnt cycle 4 (starve_cnt 0 in cycle 5), ls_gnt cycle 5.
//  4. LS store addr 0x200, wdata 0x1234_5678, be=4'b0011
//     -> mem_we=1, mem_be=0011 same cycle; no ls_rvalid; load 0x200 later returns low half 0x5678 merged.
//  5. MEM_LAT=2, IF read granted, rst asserted next cycle for 1 cycle -> no if_rvalid ever; all outputs 0 during reset.
//  6. MEM_LAT=3, alternating IF/LS loads 6 cycles -> rvalids 3 cycles after each grant, routed to correct owner, in order.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: response ownership and
// the per-stage record carried by the response pipe.
package mem_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   is_read;
    } resp_slot_t;

    localparam resp_slot_t SLOT_EMPTY = '{vld: 1'b0, owner: OWN_IF, is_read: 1'b0};

    // A slot produces read data only for the requester that issued it.
    function automatic logic slot_hits(resp_slot_t s, owner_e o);
        return s.vld && s.is_read && (s.owner == o);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, LS and memory-side signals of the arbiter.
// slave = arbiter view; master = requesters plus memory macro view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Handshake: req acts as valid, gnt as same-cycle ready. A transfer
    // happens in a cycle where req && gnt; until then the requester keeps
    // req high and every request field stable. Read data comes back later
    // as a one-cycle rvalid pulse and is never back-pressured.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_resp_pipe.sv
// Fixed-depth shift register of response slots; its tail lines up with
// the memory's read data DEPTH cycles after the access was issued.
module mem_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  resp_slot_t slot_in,
    output resp_slot_t slot_out
);

    resp_slot_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= SLOT_EMPTY;
            end
        end else begin
            stages[0] <= slot_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign slot_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the
// load/store unit: LS priority, IF starvation guard, read-data routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt;
    logic              if_win;
    logic              ls_win;
    logic              req_mux;
    logic              we_mux;
    logic [BE_W-1:0]   be_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    resp_slot_t        slot_in;
    resp_slot_t        slot_tail;
    logic              if_hit;
    logic              ls_hit;

    // LS wins a collision unless IF has already lost STARVE_MAX in a row.
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (!rst) begin
            if (bus.ls_req && !(bus.if_req && starve_cnt == CNT_MAX)) begin
                ls_win = 1'b1;
            end else if (bus.if_req) begin
                if_win = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.if_req || if_win) begin
            starve_cnt <= '0;
        end else if (ls_win && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        req_mux   = 1'b0;
        we_mux    = 1'b0;
        be_mux    = '0;
        addr_mux  = '0;
        wdata_mux = '0;
        if (ls_win) begin
            req_mux   = 1'b1;
            we_mux    = bus.ls_we;
            be_mux    = bus.ls_we ? bus.ls_be : '1;
            addr_mux  = bus.ls_addr;
            wdata_mux = bus.ls_wdata;
        end else if (if_win) begin
            req_mux  = 1'b1;
            be_mux   = '1;
            addr_mux = bus.if_addr;
        end
    end

    assign bus.if_gnt    = if_win;
    assign bus.ls_gnt    = ls_win;
    assign bus.mem_req   = req_mux;
    assign bus.mem_we    = we_mux;
    assign bus.mem_be    = be_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    always_comb begin
        slot_in         = SLOT_EMPTY;
        slot_in.vld     = if_win | ls_win;
        slot_in.owner   = ls_win ? OWN_LS : OWN_IF;
        slot_in.is_read = if_win | (ls_win & ~bus.ls_we);
    end

    mem_resp_pipe #(
        .DEPTH (MEM_LAT)
    ) u_resp_pipe (
        .clk      (clk),
        .rst      (rst),
        .slot_in  (slot_in),
        .slot_out (slot_tail)
    );

    // Gating with rst keeps a read that would land in the reset cycle silent.
    assign if_hit = !rst && slot_hits(slot_tail, OWN_IF);
    assign ls_hit = !rst && slot_hits(slot_tail, OWN_LS);

    assign bus.if_rvalid = if_hit;
    assign bus.if_rdata  = if_hit ? bus.mem_rdata : '0;
    assign bus.ls_rvalid = ls_hit;
    assign bus.ls_rdata  = ls_hit ? bus.mem_rdata : '0;

    if_req_held : assert property (@(posedge clk) disable iff (rst)
        (bus.if_req && !bus.if_gnt) |=> bus.if_req);
    ls_req_held : assert property (@(posedge clk) disable iff (rst)
        (bus.ls_req && !bus.ls_gnt) |=> bus.ls_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (MEM_LAT 1, 2, 3) with one shared directed sequence
// and checks grants, memory-side muxing and routed read responses.
module tb_mem_port_arbiter;

    localparam int W    = 49;  // {issue_cycle[15:0], owner, data[31:0]}
    localparam int NINS = 3;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;

    logic [NINS-1:0] if_gnt_v, ls_gnt_v, if_rvalid_v, ls_rvalid_v, mem_req_v, mem_we_v;
    logic [3:0]      mem_be_a    [NINS];
    logic [31:0]     mem_addr_a  [NINS];
    logic [31:0]     mem_wdata_a [NINS];
    logic [31:0]     if_rdata_a  [NINS];
    logic [31:0]     ls_rdata_a  [NINS];

    logic [31:0]  ref_mem [256];
    logic [W-1:0] exp_q[$];
    int           rd_ptr [NINS];
    int           cyc;
    int           checks;
    int           errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NINS; g++) begin : g_inst
        localparam int LAT = g + 1;

        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        logic [31:0] mem     [256];
        logic [31:0] rd_pipe [LAT];

        assign bus.if_req   = if_req;
        assign bus.if_addr  = if_addr;
        assign bus.ls_req   = ls_req;
        assign bus.ls_we    = ls_we;
        assign bus.ls_be    = ls_be;
        assign bus.ls_addr  = ls_addr;
        assign bus.ls_wdata = ls_wdata;
        assign bus.mem_rdata = rd_pipe[LAT-1];

        assign if_gnt_v[g]    = bus.if_gnt;
        assign ls_gnt_v[g]    = bus.ls_gnt;
        assign if_rvalid_v[g] = bus.if_rvalid;
        assign ls_rvalid_v[g] = bus.ls_rvalid;
        assign mem_req_v[g]   = bus.mem_req;
        assign mem_we_v[g]    = bus.mem_we;
        assign mem_be_a[g]    = bus.mem_be;
        assign mem_addr_a[g]  = bus.mem_addr;
        assign mem_wdata_a[g] = bus.mem_wdata;
        assign if_rdata_a[g]  = bus.if_rdata;
        assign ls_rdata_a[g]  = bus.ls_rdata;

        mem_port_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (LAT),
            .STARVE_MAX (4)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
            mem[64]  = 32'hDEAD_BEEF;
            mem[128] = 32'hAAAA_BBBB;
        end

        // Memory macro model: write on the edge, read data LAT cycles later.
        always @(posedge clk) begin
            if (bus.mem_req && bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
            rd_pipe[0] <= mem[bus.mem_addr[9:2]];
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    task automatic check(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat%0d cycle %0d: observed=%0h expected=%0h", tag, g + 1, cyc, obs, exp);
        end
    endtask

    // Response monitor: each instance consumes the shared expected queue
    // through its own pointer, at issue cycle + its latency.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         due;
        logic         exp_ir, exp_lr;
        logic [31:0]  exp_d;
        for (int g = 0; g < NINS; g++) begin
            due = 1'b0;
            e   = '0;
            if (rst) begin
                rd_ptr[g] = exp_q.size();
            end else if (rd_ptr[g] < exp_q.size()) begin
                e = exp_q[rd_ptr[g]];
                if (int'(e[48:33]) + g + 1 == cyc) due = 1'b1;
            end
            exp_ir = due && !e[32];
            exp_lr = due && e[32];
            exp_d  = e[31:0];
            check("if_rvalid", g, 64'(if_rvalid_v[g]), 64'(exp_ir));
            check("ls_rvalid", g, 64'(ls_rvalid_v[g]), 64'(exp_lr));
            check("if_rdata", g, 64'(if_rdata_a[g]), exp_ir ? 64'(exp_d) : 64'd0);
            check("ls_rdata", g, 64'(ls_rdata_a[g]), exp_lr ? 64'(exp_d) : 64'd0);
            if (due) rd_ptr[g]++;
        end
    end

    // One cycle: drive inputs, check grant/mux at negedge, log expected reads.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic lr, input logic lw, input logic [3:0] lbe,
                        input logic [31:0] la, input logic [31:0] lwd,
                        input logic eig, input logic elg);
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lw; ls_be = lbe; ls_addr = la; ls_wdata = lwd;
        ebe   = elg ? (lw ? lbe : 4'hF) : (eig ? 4'hF : 4'h0);
        eaddr = elg ? la : (eig ? ia : 32'd0);
        @(negedge clk);
        for (int g = 0; g < NINS; g++) begin
            check("if_gnt", g, 64'(if_gnt_v[g]), 64'(eig));
            check("ls_gnt", g, 64'(ls_gnt_v[g]), 64'(elg));
            check("mem_req", g, 64'(mem_req_v[g]), 64'(eig | elg));
            check("mem_we", g, 64'(mem_we_v[g]), 64'(elg & lw));
            check("mem_be", g, 64'(mem_be_a[g]), 64'(ebe));
            check("mem_addr", g, 64'(mem_addr_a[g]), 64'(eaddr));
            check("mem_wdata", g, 64'(mem_wdata_a[g]), elg ? 64'(lwd) : 64'd0);
        end
        if (eig) exp_q.push_back({cyc[15:0], 1'b0, ref_mem[ia[9:2]]});
        if (elg && !lw) exp_q.push_back({cyc[15:0], 1'b1, ref_mem[la[9:2]]});
        if (elg && lw) begin
            for (int b = 0; b < 4; b++) begin
                if (lbe[b]) ref_mem[la[9:2]][8*b +: 8] = lwd[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i + 1);
        ref_mem[64]  = 32'hDEAD_BEEF;
        ref_mem[128] = 32'hAAAA_BBBB;
        for (int g = 0; g < NINS; g++) rd_ptr[g] = 0;
        rst = 1'b1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset must not be granted.
        step(1, 32'h10, 1, 0, 4'h0, 32'h100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(1);

        // Back-to-back IF fetches.
        step(1, 32'h0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0, 1, 0);
        step(1, 32'h8, 0, 0, 0, 0, 0, 1, 0);
        step(1, 32'hC, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Collision: LS first, IF the cycle after.
        step(1, 32'h10, 1, 0, 4'h0, 32'h100, 32'h5555_0000, 0, 1);
        step(1, 32'h10, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Starvation guard: IF forced through after four LS wins.
        for (int k = 0; k < 6; k++) begin
            step(1, 32'h40, 1, 0, 4'h0, 32'h20 + 32'(4 * k), 0, (k == 4), (k != 4));
        end
        step(1, 32'h44, 0, 0, 0, 0, 0, 1, 0);

        // Partial store followed immediately by a load of the same word.
        step(0, 0, 1, 1, 4'b0011, 32'h200, 32'h1234_5678, 0, 1);
        step(0, 0, 1, 0, 4'h0, 32'h200, 0, 0, 1);

        // Random IF fetch addresses.
        for (int k = 0; k < 6; k++) begin
            step(1, 32'($urandom_range(0, 63)) << 2, 0, 0, 0, 0, 0, 1, 0);
        end
        idle(3);

        // Reset one cycle after a read grant: response must never appear.
        step(1, 32'h8, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(4);

        // Alternating IF / LS loads.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) step(1, 32'(4 * k), 0, 0, 0, 0, 0, 1, 0);
            else            step(0, 0, 1, 0, 4'h0, (k == 3) ? 32'h200 : 32'h100 + 32'(4 * k), 0, 0, 1);
        end
        idle(5);

        for (int g = 0; g < NINS; g++) begin
            check("responses_drained", g, 64'(rd_ptr[g]), 64'(exp_q.size()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
